ram_pipe: RTL and testbench
===========================

Name: ram_pipe

Overview:
Parametrised single-port synchronous RAM that succeeds the fixed 64-bit async-read RAM used by the datapath. It adds a valid/ready request handshake, byte-enable writes and a registered read pipeline of configurable depth. A reset-time clear sequencer zeroes the array, and out-of-range accesses are flagged. It sits between the control FSM and data storage, and its outputs are timing-clean for larger DEPTH.

Parameters:
DW, 64, data width in bits; must be a multiple of 8.
AW, 14, address width in bits.
DEPTH, 10485, number of words; must satisfy DEPTH <= 2**AW.
READ_LAT, 1, read latency in cycles from accepted request to rsp_valid; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents retained across reset.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = write, 0 = read.
req_adr  in  AW  word address.
req_wdata  in  DW  write data.
req_be  in  DW/8  byte enables for writes; bit i covers bits [8i+7:8i].
rsp_valid  out  1  read response valid, one-cycle pulse per accepted read.
rsp_data  out  DW  read data; 0 when rsp_err is set.
rsp_err  out  1  accepted read or write had req_adr >= DEPTH; valid with rsp_valid for reads, one-cycle pulse for writes.
init_done  out  1  clear sequence finished; stays 1 until the next rst.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0; the read pipeline is flushed.
- FSM states: CLEAR, RUN.
  - rst forces CLEAR with clr_adr=0.
  - CLEAR, CLEAR_ON_RESET=1: one word per cycle, mem[clr_adr] <= 0 and clr_adr increments. After writing DEPTH-1 the FSM moves to RUN, so clearing takes exactly DEPTH cycles after rst deasserts.
  - CLEAR, CLEAR_ON_RESET=0: moves to RUN on the first cycle after rst deasserts, with no writes.
  - RUN: req_ready=1 and init_done=1 from the first cycle in RUN. RUN persists until rst.
- Handshake: a request is accepted when req_valid && req_ready. Requests are ignored in CLEAR. There is no response backpressure.
- Write, accepted at cycle T:
  - For each i with req_be[i]=1, byte i of mem[req_adr] is updated at the T edge; bytes with req_be[i]=0 are unchanged.
  - req_be=0 is a legal no-op write.
  - A read accepted at T+1 to the same address returns the new data.
  - No response is produced, except rsp_err pulses at T+1 if the address is out of range.
- Read, accepted at cycle T:
  - rsp_valid=1 and rsp_data=mem[req_adr] at cycle T+READ_LAT.
  - Back-to-back reads give back-to-back responses in order, so sustained throughput is 1 per cycle.
  - With READ_LAT=2, data is registered once more after the array read.
- Out of range (req_adr >= DEPTH): writes do not modify memory. Reads return rsp_data=0 with rsp_err=1. Addresses are never wrapped modulo DEPTH.
- rsp_data holds its last value when rsp_valid=0.
- Reset during CLEAR restarts clearing from address 0.
- Reset during RUN with reads in flight drops those responses; no rsp_valid appears after rst.
- A write accepted in the same cycle rst is asserted is discarded.
- Width rules: byte lane count is DW/8. The clear counter is AW+1 bits so that DEPTH = 2**AW terminates correctly.

Test Plan:
1. DEPTH=16, CLEAR_ON_RESET=1, array preloaded nonzero. Pulse rst for 2 cycles -> init_done rises exactly 16 cycles after rst falls; reads of addresses 0..15 all return 0.
2. Write adr 5 = 64'h1122334455667788 with be=8'hFF, then write 64'hAAAAAAAAAAAAAAAA with be=8'h0F, then read adr 5 -> 64'h11223344AAAAAAAA.
3. READ_LAT=2, reads of adr 1,2,3 on consecutive cycles holding 10,20,30 -> rsp_valid high for 3 consecutive cycles starting 2 cycles after the first accept, with data 10,20,30 in order.
4. DEPTH=16: write adr 20 = 64'hFF, then read adr 20 and adr 4 -> write causes an rsp_err pulse; read of 20 returns 0 with rsp_err=1; read of 4 is unchanged with rsp_err=0.
5. Assert rst with 1 read in flight (READ_LAT=2), then restart with CLEAR_ON_RESET=0 -> no rsp_valid appears after rst; req_ready=1 one cycle after rst falls; previously written data is retained.
6. req_valid held high throughout CLEAR -> nothing is accepted and no responses appear; the first accept happens in the first RUN cycle.

Source files
------------

// File: rtl/ram_pipe.sv
// Single-port synchronous RAM: valid/ready requests, byte-enable writes, a 1- or 2-stage
// registered read path, out-of-range flagging and a post-reset array clear sequencer.
module ram_pipe #(
   parameter int unsigned DW             = 64,
   parameter int unsigned AW             = 14,
   parameter int unsigned DEPTH          = 10485,
   parameter int unsigned READ_LAT       = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_adr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_be,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_data,
   output logic            rsp_err,
   output logic            init_done
);

   localparam int unsigned NB      = DW / 8;
   localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DepthC  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LastAdr = (AW+1)'(DEPTH - 1);

   typedef enum logic {StClear, StRun} state_e;

   state_e        state_q, state_d;
   logic [AW:0]   clr_adr_q, clr_adr_d;
   logic          clr_we;

   logic [DW-1:0] mem [DEPTH];

   logic          accept, in_range, wr_en, rd_en;
   logic [IW-1:0] acc_idx, clr_idx;

   logic          s1_valid_q, s1_valid_d;
   logic          s1_err_q, s1_err_d;
   logic [DW-1:0] s1_data_q, s1_data_d;
   logic          wr_err_q, wr_err_d;
   logic          out_err;

   assign req_ready = (state_q == StRun);
   assign init_done = (state_q == StRun);

   // Compare on AW+1 bits so DEPTH = 2**AW never flags a legal address.
   assign in_range = ({1'b0, req_adr} < DepthC);
   assign accept   = req_valid && req_ready && !rst;
   assign wr_en    = accept && req_we && in_range;
   assign rd_en    = accept && !req_we;
   assign acc_idx  = req_adr[IW-1:0];
   assign clr_idx  = clr_adr_q[IW-1:0];

   always_comb begin
      state_d   = state_q;
      clr_adr_d = clr_adr_q;
      clr_we    = 1'b0;
      unique case (state_q)
         StClear: begin
            if (CLEAR_ON_RESET) begin
               clr_we    = !rst;
               clr_adr_d = clr_adr_q + (AW+1)'(1);
               if (clr_adr_q == LastAdr) begin
                  state_d = StRun;
               end
            end else begin
               state_d = StRun;
            end
         end
         StRun: begin
            state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StClear;
         clr_adr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_adr_q <= clr_adr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (req_be[i]) begin
               mem[acc_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   // First read stage; data only moves on an accepted read so rsp_data holds otherwise.
   always_comb begin
      s1_valid_d = rd_en;
      s1_err_d   = rd_en && !in_range;
      wr_err_d   = accept && req_we && !in_range;
      s1_data_d  = s1_data_q;
      if (rd_en) begin
         s1_data_d = in_range ? mem[acc_idx] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_data_q  <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_err_q   <= s1_err_d;
         s1_data_q  <= s1_data_d;
         wr_err_q   <= wr_err_d;
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic          s2_valid_q, s2_valid_d;
         logic          s2_err_q, s2_err_d;
         logic [DW-1:0] s2_data_q, s2_data_d;

         always_comb begin
            s2_valid_d = s1_valid_q;
            s2_err_d   = s1_err_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               s2_valid_q <= 1'b0;
               s2_err_q   <= 1'b0;
               s2_data_q  <= '0;
            end else begin
               s2_valid_q <= s2_valid_d;
               s2_err_q   <= s2_err_d;
               s2_data_q  <= s2_data_d;
            end
         end

         assign rsp_valid = s2_valid_q;
         assign rsp_data  = s2_data_q;
         assign out_err   = s2_err_q;
      end else begin : g_lat1
         assign rsp_valid = s1_valid_q;
         assign rsp_data  = s1_data_q;
         assign out_err   = s1_err_q;
      end
   endgenerate

   // Write range errors share the rsp_err pin with read responses.
   assign rsp_err = out_err | wr_err_q;

endmodule

// File: tb/tb_ram_pipe.sv
// Bench for ram_pipe: two instances (cleared/latency-2 and retained/latency-1) share one
// stimulus stream and are checked by a scoreboard against a word-array reference model.
module tb_ram_pipe;

   localparam int AW    = 5;
   localparam int DEPTH = 16;

   typedef struct {
      int          due;
      logic [63:0] data;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [AW-1:0] req_adr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_be = '0;

   logic        req_ready [2];
   logic        rsp_valid [2];
   logic        rsp_err   [2];
   logic        init_done [2];
   logic [63:0] rsp_data  [2];

   always #5 clk = ~clk;

   ram_pipe #(
      .DW(64), .AW(AW), .DEPTH(DEPTH), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)
   ) u_dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
      .req_we(req_we), .req_adr(req_adr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
      .init_done(init_done[0])
   );

   ram_pipe #(
      .DW(64), .AW(AW), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1'b0)
   ) u_dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
      .req_we(req_we), .req_adr(req_adr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
      .init_done(init_done[1])
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          started = 1'b0;
   bit          run [2];
   int          clr_cnt [2];
   int          werr_cyc [2] = '{-1, -1};
   logic [63:0] mdl_mem [2][DEPTH];
   logic [63:0] last_data [2];
   rsp_t        exp_q [2][$];
   rsp_t        mdl_r;
   rsp_t        mon_e;
   logic        mdl_oor;
   logic        mon_werr;

   function automatic int lat_of(int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic bit clears(int k);
      return (k == 0);
   endfunction

   task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
      end
   endtask

   // Reference model: advances once per clock edge from the driven inputs.
   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            started      = 1'b1;
            run[k]       = 1'b0;
            clr_cnt[k]   = 0;
            werr_cyc[k]  = -1;
            last_data[k] = '0;
            exp_q[k].delete();
         end else if (!run[k]) begin
            if (clears(k)) begin
               mdl_mem[k][clr_cnt[k]] = '0;
               clr_cnt[k]++;
               if (clr_cnt[k] == DEPTH) run[k] = 1'b1;
            end else begin
               run[k] = 1'b1;
            end
         end else if (req_valid) begin
            mdl_oor = (int'(req_adr) >= DEPTH);
            if (req_we) begin
               if (mdl_oor) begin
                  werr_cyc[k] = cyc;
               end else begin
                  for (int i = 0; i < 8; i++) begin
                     if (req_be[i]) mdl_mem[k][req_adr[3:0]][8*i +: 8] = req_wdata[8*i +: 8];
                  end
               end
            end else begin
               mdl_r.due  = cyc + lat_of(k) - 1;
               mdl_r.data = mdl_oor ? 64'h0 : mdl_mem[k][req_adr[3:0]];
               mdl_r.err  = mdl_oor;
               exp_q[k].push_back(mdl_r);
            end
         end
      end
   end

   // Monitor: samples on the falling edge, pops whenever a response is presented.
   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            chk("req_ready", k, 64'(req_ready[k]), 64'(run[k]));
            chk("init_done", k, 64'(init_done[k]), 64'(run[k]));
            mon_werr = (werr_cyc[k] == cyc);
            if (rsp_valid[k]) begin
               if (exp_q[k].size() == 0) begin
                  chk("spurious rsp_valid", k, 64'(rsp_valid[k]), 64'd0);
               end else begin
                  mon_e = exp_q[k].pop_front();
                  chk("rsp_cycle", k, 64'(cyc), 64'(mon_e.due));
                  chk("rsp_data", k, rsp_data[k], mon_e.data);
                  chk("rsp_err(read)", k, 64'(rsp_err[k]), 64'(mon_e.err | mon_werr));
                  last_data[k] = mon_e.data;
               end
            end else begin
               if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
                  mon_e = exp_q[k].pop_front();
                  chk("missing rsp_valid", k, 64'(rsp_valid[k]), 64'd1);
               end
               chk("rsp_err(idle)", k, 64'(rsp_err[k]), 64'(mon_werr));
               chk("rsp_data hold", k, rsp_data[k], last_data[k]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(bit v, bit we, int adr, logic [63:0] d, logic [7:0] be);
      req_valid = v;
      req_we    = we;
      req_adr   = AW'(adr);
      req_wdata = d;
      req_be    = be;
      tick();
   endtask

   task automatic idle(int n);
      req_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset(int n);
      rst       = 1'b1;
      req_valid = 1'b0;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   int n;
   bit done;

   initial begin
      repeat (2) tick();
      // Write held valid throughout the clear; instance a may only take it once running.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_adr   = AW'(3);
      req_wdata = 64'h0000_0000_00C0_FFEE;
      req_be    = 8'hFF;
      rst       = 1'b0;
      n         = 0;
      done      = 1'b0;
      while (!done && n < 40) begin
         tick();
         n++;
         done = init_done[0];
      end
      chk("clear_cycles", 0, 64'(n), 64'd16);
      tick();
      idle(1);

      // Preload every word nonzero, then read all back.
      for (int a = 0; a < DEPTH; a++) req(1, 1, a, {$urandom, $urandom} | 64'h1, 8'hFF);
      for (int a = 0; a < DEPTH; a++) req(1, 0, a, 64'h0, 8'h00);
      idle(3);

      // Reset, restart mid-clear, then read everything.
      do_reset(2);
      idle(5);
      do_reset(1);
      idle(20);
      for (int a = 0; a < DEPTH; a++) req(1, 0, a, 64'h0, 8'h00);
      idle(3);

      // Byte-enable merge.
      req(1, 1, 5, 64'h1122334455667788, 8'hFF);
      req(1, 1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      req(1, 0, 5, 64'h0, 8'h00);
      idle(3);

      // Back-to-back reads.
      req(1, 1, 1, 64'd10, 8'hFF);
      req(1, 1, 2, 64'd20, 8'hFF);
      req(1, 1, 3, 64'd30, 8'hFF);
      req(1, 0, 1, 64'h0, 8'h00);
      req(1, 0, 2, 64'h0, 8'h00);
      req(1, 0, 3, 64'h0, 8'h00);
      idle(3);

      // Out-of-range write and read, plus an in-range neighbour.
      req(1, 1, 20, 64'hFF, 8'hFF);
      req(1, 0, 20, 64'h0, 8'h00);
      req(1, 0, 4, 64'h0, 8'h00);
      idle(3);

      // Reset with a read in flight and a write presented during reset.
      req(1, 1, 7, 64'h5A5A_5A5A_0000_1234, 8'hFF);
      req(1, 0, 7, 64'h0, 8'h00);
      rst       = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_adr   = AW'(8);
      req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
      req_be    = 8'hFF;
      tick();
      idle(1);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", 1, 64'(req_ready[1]), 64'd1);
      idle(18);
      req(1, 0, 7, 64'h0, 8'h00);
      req(1, 0, 8, 64'h0, 8'h00);
      idle(3);

      // Randomized traffic including out-of-range addresses and sparse byte enables.
      repeat (400) begin
         req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 23),
             {$urandom, $urandom}, 8'($urandom));
      end
      idle(4);

      chk("drain", 0, 64'(exp_q[0].size()), 64'd0);
      chk("drain", 1, 64'(exp_q[1].size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
